keypad_scan_ctrl: RTL and testbench

Scan controller for the board's 4x4 key matrix. It sequences the column drives, samples and synchronises the row inputs, and debounces both press and release. Each accepted key is delivered as a single coded event through a one-entry valid/ready buffer. It replaces the ad hoc per-design column state machines: clock/set logic and other consumers read `key_code` events instead of raw row/column levels.

---
 rtl/keypad_scan_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Scan controller for a 4x4 active-low key matrix. Columns are driven one at
// a time, rows are synchronised and debounced on both press and release, and
// each accepted key becomes one coded event in a single-entry valid/ready
// buffer.
//
// Parameters:
//   COL_DWELL     cycles each column is driven while scanning (>= 3)
//   DEBOUNCE_CYC  consecutive stable cycles to accept a press or release (>= 1)
//   REPEAT_DELAY  hold cycles before the first auto-repeat (repeat build only)
//   REPEAT_PERIOD cycles between later auto-repeats (repeat build only)
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-low reset
//   key_row[3:0]  raw matrix rows, active-low, asynchronous to clk
//   key_col[3:0]  column drives, active-low, bit i drives column i
//   key_valid     event buffer holds an event
//   key_code[3:0] event code = row_index*4 + col_index
//   key_ready     consumer takes the event when key_valid & key_ready
//   key_down      a debounced key is currently held
//   key_overflow  one-cycle pulse when an event is dropped (buffer full)
//
// Build option: define KEYPAD_REPEAT_EN to generate auto-repeat events while
// a key is held. Without it exactly one event is produced per press.
module keypad_scan_ctrl #(
  parameter int COL_DWELL     = 1000,
  parameter int DEBOUNCE_CYC  = 330000,
  parameter int REPEAT_DELAY  = 16500000,
  parameter int REPEAT_PERIOD = 3300000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       key_down,
  output logic       key_overflow
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SCAN     = 3'd1;
  localparam logic [2:0] DEBOUNCE = 3'd2;
  localparam logic [2:0] PRESSED  = 3'd3;
  localparam logic [2:0] RELEASE  = 3'd4;

  // One counter serves the scan dwell and both debounce phases.
  localparam int CNT_MAX = (COL_DWELL > DEBOUNCE_CYC) ? COL_DWELL : DEBOUNCE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(COL_DWELL - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYC - 1);

  if (COL_DWELL < 3) begin : g_bad_dwell
    $error("keypad_scan_ctrl: COL_DWELL must be at least 3");
  end
  if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
    $error("keypad_scan_ctrl: DEBOUNCE_CYC must be at least 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("keypad_scan_ctrl: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  logic [3:0]    row_m;
  logic [3:0]    row_s;
  logic [3:0]    row_l;
  logic [2:0]    state;
  logic [1:0]    col;
  logic [CW-1:0] cnt;
  logic [1:0]    row_idx;
  logic          row_hit;
  logic          row_match;
  logic          push_db;
  logic          push;
  logic          pop;
  logic [3:0]    push_code;

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  // Two-flop synchroniser; idle level is all rows high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_m <= '1;
      row_s <= '1;
    end else begin
      row_m <= key_row;
      row_s <= row_m;
    end
  end

  assign row_hit   = (row_s != 4'hF);
  assign row_match = (row_s == row_l);

  // Lowest low row wins when several keys share the latched column.
  always_comb begin
    row_idx = 2'd3;
    if (!row_l[0])      row_idx = 2'd0;
    else if (!row_l[1]) row_idx = 2'd1;
    else if (!row_l[2]) row_idx = 2'd2;
  end

  assign push_code = {row_idx, col};
  assign push_db   = (state == DEBOUNCE) && row_match && (cnt == DB_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      col      <= '0;
      cnt      <= '0;
      row_l    <= '1;
      key_col  <= '0;
      key_down <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (row_hit) begin
            state   <= SCAN;
            col     <= 2'd0;
            cnt     <= '0;
            key_col <= col_drive(2'd0);
          end
        end
        SCAN: begin
          if (cnt == DWELL_LAST) begin
            cnt <= '0;
            if (row_hit) begin
              state <= DEBOUNCE;
              row_l <= row_s;
            end else if (col == 2'd3) begin
              state   <= IDLE;
              key_col <= '0;
            end else begin
              col     <= col + 2'd1;
              key_col <= col_drive(col + 2'd1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!row_match) begin
            state   <= IDLE;
            cnt     <= '0;
            key_col <= '0;
          end else if (cnt == DB_LAST) begin
            state    <= PRESSED;
            cnt      <= '0;
            key_down <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!row_hit) begin
            state <= RELEASE;
            cnt   <= '0;
          end
        end
        RELEASE: begin
          if (row_hit) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state    <= IDLE;
            cnt      <= '0;
            key_col  <= '0;
            key_down <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          col      <= '0;
          cnt      <= '0;
          key_col  <= '0;
          key_down <= 1'b0;
        end
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold_cnt;
  logic          hold_first;
  logic          push_rep;

  // hold_first selects the initial delay until the first repeat has fired.
  assign push_rep = (state == PRESSED) && row_hit &&
                    (hold_cnt == (hold_first ? DELAY_LAST : PERIOD_LAST));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt   <= '0;
      hold_first <= 1'b1;
    end else if (push_db) begin
      hold_cnt   <= '0;
      hold_first <= 1'b1;
    end else if (state == PRESSED && row_hit) begin
      if (push_rep) begin
        hold_cnt   <= '0;
        hold_first <= 1'b0;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end else begin
      hold_cnt <= '0;
    end
  end

  assign push = push_db | push_rep;
`else
  assign push = push_db;
`endif

  // Single-entry event buffer: a push with a simultaneous pop replaces the
  // entry; a push into a full buffer without a pop is dropped.
  assign pop = key_valid & key_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_valid    <= 1'b0;
      key_code     <= '0;
      key_overflow <= 1'b0;
    end else begin
      key_overflow <= push & key_valid & ~key_ready;
      if (push && (!key_valid || key_ready)) begin
        key_valid <= 1'b1;
        key_code  <= push_code;
      end else if (pop) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl
// Directed bench for keypad_scan_ctrl (COL_DWELL=4, DEBOUNCE_CYC=8). A key
// matrix model pulls a row low while its key is closed and its column is
// driven low. Stimulus pushes expected codes into exp_q; the monitor pops and
// compares on every accepted event. Define KEYPAD_REPEAT_EN to cover repeats.
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;

  localparam int COL_DWELL     = 4;
  localparam int DEBOUNCE_CYC  = 8;
  localparam int REPEAT_DELAY  = 20;
  localparam int REPEAT_PERIOD = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready = 1'b0;
  logic       key_down;
  logic       key_overflow;

  logic [15:0] keys = '0;  // index = row*4 + col
  logic [3:0]  exp_q[$];
  int          evt_t[$];
  logic [3:0]  exp_code;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ovf_seen = 0;

  keypad_scan_ctrl #(
    .COL_DWELL    (COL_DWELL),
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_row     (key_row),
    .key_col     (key_col),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .key_down    (key_down),
    .key_overflow(key_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && key_col[c] === 1'b0) key_row[r] = 1'b0;
  end

  // Monitor: every handshake must match the oldest expected code.
  always @(negedge clk) begin
    if (reset) begin
      if (key_overflow) ovf_seen++;
      if (key_valid && key_ready) begin
        evt_t.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL event_unexpected actual=%0d required=none", key_code);
        end else begin
          exp_code = exp_q.pop_front();
          if (key_code !== exp_code) begin
            failures++;
            $display("FAIL event_code actual=%0d required=%0d", key_code, exp_code);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Negedges until key_down reaches lvl; -1 if the budget runs out.
  task automatic wait_down(input logic lvl, input int limit, output int n);
    n = 0;
    while (key_down !== lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (key_down !== lvl) n = -1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int ovf0;

    // Reset values
    keys = '0;
    repeat (3) @(negedge clk);
    check("rst_key_col", key_col, 4'b0000);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_down", key_down, 1'b0);
    check("rst_key_overflow", key_overflow, 1'b0);
    step(1);
    reset = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (key_col !== 4'b0000 || key_valid !== 1'b0) bad++;
    end
    check("idle_after_reset", bad, 0);

    // Clean press: row 2 / col 1 -> code 9, held 100 cycles
    step(1);
    key_ready = 1'b1;
    keys[9] = 1'b1;
    exp_q.push_back(4'd9);
`ifdef KEYPAD_REPEAT_EN
    repeat (7) exp_q.push_back(4'd9);
`endif
    wait_down(1'b1, 60, n);
    check("clean_latency", n, 20);
    step(81);
    keys[9] = 1'b0;
    wait_down(1'b0, 40, n);
    check("clean_release_latency", n, 12);
    step(10);
    check("clean_col_idle", key_col, 4'b0000);

    // Bounce: row 0 / col 3 -> code 3
    repeat (5) begin
      keys[3] = 1'b1;
      step(3);
      keys[3] = 1'b0;
      step(3);
    end
    keys[3] = 1'b1;
    exp_q.push_back(4'd3);
    wait_down(1'b1, 80, n);
    check("bounce_accept", (n >= 0), 1'b1);
    step(5);
    repeat (2) begin
      keys[3] = 1'b0;
      step(3);
      keys[3] = 1'b1;
      step(3);
    end
    check("bounce_release_held", key_down, 1'b1);
    keys[3] = 1'b0;
    wait_down(1'b0, 60, n);
    check("bounce_release", (n >= 0), 1'b1);
    step(10);

    // Glitch: 2-cycle low on row 1 / col 2
    keys[6] = 1'b1;
    step(2);
    keys[6] = 1'b0;
    step(40);
    check("glitch_col_idle", key_col, 4'b0000);
    check("glitch_no_down", key_down, 1'b0);

    // Backpressure: key 0 held in buffer, key 5 dropped
    key_ready = 1'b0;
    ovf0 = ovf_seen;
    keys[0] = 1'b1;
    wait_down(1'b1, 80, n);
    step(3);
    keys[0] = 1'b0;
    wait_down(1'b0, 60, n);
    step(5);
    keys[5] = 1'b1;
    wait_down(1'b1, 80, n);
    check("bp_second_accept", (n >= 0), 1'b1);
    step(3);
    keys[5] = 1'b0;
    wait_down(1'b0, 60, n);
    step(5);
    check("bp_overflow_pulses", ovf_seen - ovf0, 1);
    check("bp_valid_held", key_valid, 1'b1);
    check("bp_code_held", key_code, 4'd0);
    exp_q.push_back(4'd0);
    step(1);
    key_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_fall", key_valid, 1'b0);

    // Reset during DEBOUNCE drops a pending event and the column drive
    key_ready = 1'b0;
    keys[15] = 1'b1;
    wait_down(1'b1, 80, n);
    step(3);
    keys[15] = 1'b0;
    wait_down(1'b0, 60, n);
    step(5);
    keys[4] = 1'b1;
    repeat (9) @(negedge clk);
    check("deb_col_driven", key_col, 4'b1110);
    check("deb_pending_valid", key_valid, 1'b1);
    reset = 1'b0;
    #1;
    check("async_rst_key_col", key_col, 4'b0000);
    check("async_rst_key_valid", key_valid, 1'b0);
    check("async_rst_key_down", key_down, 1'b0);
    keys = '0;
    step(3);
    reset = 1'b1;
    key_ready = 1'b1;
    step(30);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: key 6 held 55 cycles after acceptance
    evt_t.delete();
    keys[6] = 1'b1;
    repeat (5) exp_q.push_back(4'd6);
    wait_down(1'b1, 80, n);
    step(55);
    keys[6] = 1'b0;
    wait_down(1'b0, 60, n);
    step(5);
    check("rep_event_count", evt_t.size(), 5);
    if (evt_t.size() == 5) begin
      check("rep_first_gap", evt_t[1] - evt_t[0], 20);
      check("rep_gap_2", evt_t[2] - evt_t[1], 10);
      check("rep_gap_3", evt_t[3] - evt_t[2], 10);
      check("rep_gap_4", evt_t[4] - evt_t[3], 10);
    end
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
